// File: rtl/shift_sequencer_if.sv
// Request/result bus of the multi-cycle shift sequencer.
//
// Handshake rules, both directions:
//   - A transfer happens on a rising clock edge where valid and ready are both high.
//   - Request side: valid_i/sel_i/A_i/shamt_i come from the master; ready_o comes
//     from the sequencer and is high only while it is idle.
//   - Result side: valid_o/data_o come from the sequencer; ready_i comes from the
//     consumer. While valid_o is high and ready_i is low, data_o does not change.
interface shift_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             valid_i;
    logic             ready_o;
    logic [1:0]       sel_i;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] shamt_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             busy_o;

    // Sequencer side
    modport slave (
        input  valid_i, sel_i, A_i, shamt_i, ready_i,
        output ready_o, valid_o, data_o, busy_o
    );

    // Requester / consumer side
    modport master (
        output valid_i, sel_i, A_i, shamt_i, ready_i,
        input  ready_o, valid_o, data_o, busy_o
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one request, applies one single-bit shift per clock
// until the effective amount is used up, then presents the result until taken.
// Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
module shift_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    shift_sequencer_if.slave    bus,
    output logic [1:0]          dbg_state_o
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       sel_q, sel_d;

    logic [CW-1:0]    eff_n;
    logic [WIDTH-1:0] shifted;

    // Effective amount: linear shifts saturate at WIDTH, rotates wrap modulo WIDTH.
    always_comb begin
        eff_n = '0;
        if (bus.sel_i == OP_ROR) begin
            eff_n = CW'(bus.shamt_i % WIDTH'(WIDTH));
        end else if (bus.shamt_i >= WIDTH'(WIDTH)) begin
            eff_n = CW'(WIDTH);
        end else begin
            eff_n = bus.shamt_i[CW-1:0];
        end
    end

    // One single-bit stage of the latched operation applied to the data register.
    always_comb begin
        shifted = data_q;
        case (sel_q)
            OP_SLL:  shifted = {data_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, data_q[WIDTH-1:1]};
            OP_SRA:  shifted = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            OP_ROR:  shifted = {data_q[0], data_q[WIDTH-1:1]};
            default: shifted = data_q;
        endcase
    end

    // Next-state logic: accept in IDLE, step in SHIFT, wait for the consumer in DONE.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    data_d  = bus.A_i;
                    sel_d   = bus.sel_i;
                    count_d = eff_n;
                    state_d = (eff_n == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d  = shifted;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE first leaves a one-cycle bubble before the next accept.
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            sel_q   <= OP_SLL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q == DONE);
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.data_o  = data_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer (WIDTH=8): directed vector table, random ops against an
// arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_shift_sequencer;
    localparam int W = 8;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] a;
        logic [7:0] shamt;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    logic       clk;
    logic       rst_i;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];

    shift_sequencer_if #(.WIDTH(W)) bus ();

    shift_sequencer #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // reference model: plain arithmetic on the operation definitions
    function automatic int ref_n(input logic [1:0] sel, input logic [7:0] sh);
        if (sel == 2'b11) return int'(sh) % W;
        return (int'(sh) > W) ? W : int'(sh);
    endfunction

    function automatic logic [7:0] ref_data(input logic [1:0] sel, input logic [7:0] a,
                                            input logic [7:0] sh);
        int n;
        logic [7:0] r;
        n = ref_n(sel, sh);
        case (sel)
            2'b00:   r = a << n;
            2'b01:   r = a >> n;
            2'b10:   r = $signed(a) >>> n;
            default: r = (a >> n) | (a << (W - n));
        endcase
        return r;
    endfunction

    // driver: issue one request with ready_i high, measure edges until valid_o
    task automatic run_op(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] sh,
                          output logic [7:0] got, output int edges);
        @(negedge clk);
        chk("idle_ready_before_req", bus.ready_o, 1);
        bus.valid_i = 1'b1;
        bus.sel_i   = sel;
        bus.A_i     = a;
        bus.shamt_i = sh;
        @(posedge clk);
        #1;
        edges = 1;
        bus.valid_i = 1'b0;
        bus.sel_i   = 2'($urandom);
        bus.A_i     = 8'($urandom);
        bus.shamt_i = 8'($urandom);
        while (!bus.valid_o && edges < 40) begin
            chk("ready_low_while_shifting", bus.ready_o, 0);
            chk("busy_while_shifting", bus.busy_o, 1);
            @(posedge clk);
            #1;
            edges++;
        end
        chk("valid_reached", bus.valid_o, 1);
        chk("busy_in_done", bus.busy_o, 1);
        got = bus.data_o;
        @(posedge clk);
        #1;
        chk("idle_after_consume_ready", bus.ready_o, 1);
        chk("idle_after_consume_valid", bus.valid_o, 0);
    endtask

    vec_t       vecs[10];
    logic [7:0] got;
    int         edges;

    initial begin
        vecs[0] = '{2'b00, 8'h81, 8'd3,   8'h08, 4};
        vecs[1] = '{2'b01, 8'h90, 8'd2,   8'h24, 3};
        vecs[2] = '{2'b10, 8'h90, 8'd2,   8'hE4, 3};
        vecs[3] = '{2'b00, 8'h5A, 8'd0,   8'h5A, 1};
        vecs[4] = '{2'b01, 8'h5A, 8'd0,   8'h5A, 1};
        vecs[5] = '{2'b10, 8'h5A, 8'd0,   8'h5A, 1};
        vecs[6] = '{2'b11, 8'h5A, 8'd0,   8'h5A, 1};
        vecs[7] = '{2'b11, 8'h01, 8'd9,   8'h80, 2};
        vecs[8] = '{2'b00, 8'hFF, 8'hC8,  8'h00, 9};
        vecs[9] = '{2'b10, 8'h80, 8'hFF,  8'hFF, 9};

        // reset
        rst_i       = 1'b1;
        bus.valid_i = 1'b0;
        bus.sel_i   = 2'b00;
        bus.A_i     = '0;
        bus.shamt_i = '0;
        bus.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_data", bus.data_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        // directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].shamt, got, edges);
            chk($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
            chk($sformatf("vec%0d_latency", i), edges, vecs[i].exp_lat);
        end

        // random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] s;
            logic [7:0] a;
            logic [7:0] sh;
            s  = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            sh = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
            exp_q.push_back(ref_data(s, a, sh));
            lat_q.push_back(ref_n(s, sh) + 1);
            run_op(s, a, sh, got, edges);
            chk($sformatf("rand%0d_data", i), got, exp_q.pop_front());
            chk($sformatf("rand%0d_latency", i), edges, lat_q.pop_front());
        end

        // backpressure in DONE, blocked concurrent request, then bubble and accept
        @(negedge clk);
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.sel_i   = 2'b01;
        bus.A_i     = 8'h90;
        bus.shamt_i = 8'd2;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        edges = 1;
        while (!bus.valid_o && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("bp_latency", edges, 3);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.sel_i   = 2'b00;
        bus.A_i     = 8'h01;
        bus.shamt_i = 8'd1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_valid_held", bus.valid_o, 1);
            chk("bp_data_held", bus.data_o, 8'h24);
            chk("bp_ready_low", bus.ready_o, 0);
        end
        @(negedge clk);
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_bubble_idle", bus.ready_o, 1);
        chk("bp_bubble_valid", bus.valid_o, 0);
        @(posedge clk);
        #1;
        chk("bp_accept_ready", bus.ready_o, 0);
        chk("bp_accept_busy", bus.busy_o, 1);
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_next_valid", bus.valid_o, 1);
        chk("bp_next_data", bus.data_o, 8'h02);
        @(posedge clk);
        #1;
        chk("bp_next_consumed", bus.ready_o, 1);

        // reset asserted between edges in the middle of a shift
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.sel_i   = 2'b00;
        bus.A_i     = 8'hFF;
        bus.shamt_i = 8'd8;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_busy", bus.busy_o, 1);
        rst_i = 1'b1;
        #1;
        chk("midrst_valid", bus.valid_o, 0);
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_data", bus.data_o, 0);
        chk("midrst_ready", bus.ready_o, 1);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_no_result", bus.valid_o, 0);
        run_op(2'b11, 8'h01, 8'd9, got, edges);
        chk("post_rst_data", got, 8'h80);
        chk("post_rst_latency", edges, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
